// File: rtl/adc0809_reader.sv
// ADC0809 conversion sequencer: generates the ADC clock, drives ADDR/ALE/START/OE
// from a single FSM and returns each converted byte with a one-cycle valid strobe.
module adc0809_reader #(
  parameter int unsigned CLK_HALF  = 100,
  parameter int unsigned SETUP_CYC = 4,
  parameter int unsigned PULSE_CYC = 50,
  parameter int unsigned OE_CYC    = 50,
  parameter int unsigned TIMEOUT   = 20000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [2:0] ch_sel,
  input  logic       eoc,
  input  logic [7:0] adc_data,
  output logic       adc_clk,
  output logic [2:0] adc_addr,
  output logic       ale,
  output logic       start,
  output logic       oe,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       timeout_err
);

  localparam int unsigned MAX_SP  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int unsigned MAX_OT  = (OE_CYC > TIMEOUT) ? OE_CYC : TIMEOUT;
  localparam int unsigned MAX_CYC = (MAX_SP > MAX_OT) ? MAX_SP : MAX_OT;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
  localparam int unsigned DIV_W   = $clog2(CLK_HALF + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    PULSE   = 3'd2,
    WAIT_LO = 3'd3,
    WAIT_HI = 3'd4,
    READ    = 3'd5
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [DIV_W-1:0] div_cnt;
  logic             eoc_m;
  logic             eoc_s;

  // Free-running conversion clock, independent of the sequencer.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      adc_clk <= 1'b0;
    end else if (div_cnt == DIV_W'(CLK_HALF - 1)) begin
      div_cnt <= '0;
      adc_clk <= ~adc_clk;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // EOC is asynchronous; bring it into the clk domain before the FSM looks at it.
  always_ff @(posedge clk) begin
    if (rst) begin
      eoc_m <= 1'b1;
      eoc_s <= 1'b1;
    end else begin
      eoc_m <= eoc;
      eoc_s <= eoc_m;
    end
  end

  // Sequencer; cnt is cleared on every state entry so each phase counts from zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      adc_addr    <= 3'd0;
      ale         <= 1'b0;
      start       <= 1'b0;
      oe          <= 1'b0;
      data_out    <= 8'd0;
      data_valid  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      data_valid  <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (en) begin
            adc_addr <= ch_sel;
            state    <= SETUP;
          end
        end
        SETUP: begin
          if (cnt == CNT_W'(SETUP_CYC - 1)) begin
            cnt   <= '0;
            ale   <= 1'b1;
            start <= 1'b1;
            state <= PULSE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        PULSE: begin
          if (cnt == CNT_W'(PULSE_CYC - 1)) begin
            cnt   <= '0;
            ale   <= 1'b0;
            start <= 1'b0;
            state <= WAIT_LO;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        WAIT_LO: begin
          if (!eoc_s) begin
            cnt   <= '0;
            state <= WAIT_HI;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            cnt         <= '0;
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        WAIT_HI: begin
          if (eoc_s) begin
            cnt   <= '0;
            oe    <= 1'b1;
            state <= READ;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            cnt         <= '0;
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        READ: begin
          if (cnt == CNT_W'(OE_CYC - 1)) begin
            cnt        <= '0;
            oe         <= 1'b0;
            data_out   <= adc_data;
            data_valid <= 1'b1;
            state      <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          cnt   <= '0;
          ale   <= 1'b0;
          start <= 1'b0;
          oe    <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
